// File: rtl/priority_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder_stream
// Description : Streaming 8-to-3 priority encoder with one-hot checking.
//               Each accepted word is encoded to the index of its highest set
//               bit, flagged when it is not exactly one-hot (out_err) or all
//               zeros (out_zero), and queued in a 2-entry result FIFO with
//               valid/ready handshakes on both sides. A saturating counter
//               tracks how many erroneous words have been accepted.
// Ports       : clk        - sole clock, rising edge
//               rst_n      - asynchronous assert, active-low reset
//               in_valid   - upstream word valid
//               in_ready   - block can accept a word this cycle
//               in_data    - word to encode (bit 7 highest priority)
//               out_valid  - out_code/out_err/out_zero hold a result
//               out_ready  - downstream accepts the presented result
//               out_code   - index of highest set bit
//               out_err    - word was not exactly one-hot
//               out_zero   - word was all zeros
//               err_count  - saturating count of accepted erroneous words
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder_stream #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_code,
    output logic                 out_err,
    output logic                 out_zero,
    output logic [ERR_CNT_W-1:0] err_count
);

    // FIFO occupancy encoding
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    // Result word layout: {code[2:0], err, zero}
    localparam int         c_RES_W    = 5;
    localparam logic [c_RES_W-1:0] c_RES_CLEAR = '0;
    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX = '1;

    logic [1:0]           r_state;
    logic [c_RES_W-1:0]   r_head;     // result currently presented downstream
    logic [c_RES_W-1:0]   r_tail;     // second result, valid only in FULL
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [2:0]           w_code;
    logic                 w_zero;
    logic                 w_onehot;
    logic                 w_err;
    logic [c_RES_W-1:0]   w_result;
    logic                 w_push;
    logic                 w_pop;

    // ------------------------------------------------------------------------
    // Encoder: an ascending scan lets the highest set bit win.
    // ------------------------------------------------------------------------
    always_comb begin
        w_code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (in_data[i]) begin
                w_code = 3'(i);
            end
        end
    end

    // Exactly one bit set <=> non-zero and clearing the lowest set bit
    // leaves nothing behind.
    assign w_zero   = (in_data == 8'h00);
    assign w_onehot = !w_zero && ((in_data & (in_data - 8'd1)) == 8'h00);
    assign w_err    = !w_onehot;
    assign w_result = {w_code, w_err, w_zero};

    // ------------------------------------------------------------------------
    // Handshakes. Both ready and valid decode the registered state only, so
    // there is no combinational path from out_ready to in_ready.
    // ------------------------------------------------------------------------
    assign in_ready  = (r_state != c_ST_FULL);
    assign out_valid = (r_state != c_ST_EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // ------------------------------------------------------------------------
    // FIFO state machine and storage. The head register is cleared whenever
    // the FIFO drains so the result outputs read zero while EMPTY.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_EMPTY;
            r_head  <= c_RES_CLEAR;
            r_tail  <= c_RES_CLEAR;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_push) begin
                        r_head  <= w_result;
                        r_state <= c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= w_result;
                    end else if (w_push) begin
                        r_tail  <= w_result;
                        r_state <= c_ST_FULL;
                    end else if (w_pop) begin
                        r_head  <= c_RES_CLEAR;
                        r_state <= c_ST_EMPTY;
                    end
                end
                c_ST_FULL: begin
                    // in_ready is low here, so a pop is the only movement.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= c_ST_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_EMPTY;
                    r_head  <= c_RES_CLEAR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Error counter: counts at push time, sticks at all-ones.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_push && w_err && (r_err_count != c_ERR_MAX)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign out_code  = r_head[4:2];
    assign out_err   = r_head[1];
    assign out_zero  = r_head[0];
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_encoder_stream
// Description : Self-checking bench for priority_encoder_stream. A queue
//               based reference model tracks the expected result stream and
//               error count; directed scenarios are followed by random
//               traffic. A second instance with a 2-bit counter covers
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_encoder_stream;

    typedef struct packed {
        logic [2:0] code;
        logic       err;
        logic       zero;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_err;
    logic       out_zero;
    logic [7:0] err_count;

    // Saturation instance
    logic       in_valid2;
    logic       in_ready2;
    logic [7:0] in_data2;
    logic       out_valid2;
    logic       out_ready2;
    logic [2:0] out_code2;
    logic       out_err2;
    logic       out_zero2;
    logic [1:0] err_count2;

    int   n_cmp;
    int   n_fail;
    res_t q[$];
    int   m_err;

    priority_encoder_stream #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_err(out_err), .out_zero(out_zero),
        .err_count(err_count)
    );

    priority_encoder_stream #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_code(out_code2), .out_err(out_err2), .out_zero(out_zero2),
        .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding straight from the rules: highest set bit, one-hot
    // test by population count.
    function automatic res_t enc(input logic [7:0] d);
        res_t r;
        logic found;
        r     = '0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!found && d[i]) begin
                r.code = 3'(i);
                found  = 1'b1;
            end
        end
        r.err  = ($countones(d) != 1);
        r.zero = (d == 8'h00);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        res_t h;
        h = (q.size() > 0) ? q[0] : '0;
        check({tag, ":out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        check({tag, ":in_ready"},  32'(in_ready),  32'(q.size() < 2));
        check({tag, ":out_code"},  32'(out_code),  32'(h.code));
        check({tag, ":out_err"},   32'(out_err),   32'(h.err));
        check({tag, ":out_zero"},  32'(out_zero),  32'(h.zero));
        check({tag, ":err_count"}, 32'(err_count), 32'(m_err));
    endtask

    // One clock of traffic: drive (just after a falling edge), advance the
    // model across the rising edge, then check at the next falling edge.
    task automatic cycle(input string tag, input logic v, input logic [7:0] d, input logic r);
        logic push;
        logic pop;
        res_t e;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        push = v && (q.size() < 2);
        pop  = r && (q.size() > 0);
        e    = enc(d);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(e);
            if (e.err && m_err < 255) m_err++;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        m_err      = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = 8'h00;
        out_ready2 = 1'b1;

        repeat (3) @(negedge clk);
        check_all("reset_held");
        rst_n = 1'b1;
        check_all("reset_released");

        // Sweep of all one-hot codes, downstream always ready
        for (int i = 0; i < 8; i++) begin
            cycle("sweep", 1'b1, 8'(1 << i), 1'b1);
            check("sweep_code", 32'(out_code), 32'(i));
        end
        cycle("sweep_drain", 1'b0, 8'h00, 1'b1);
        check("sweep_errcnt", 32'(err_count), 32'd0);

        // Erroneous words
        cycle("err_zero", 1'b1, 8'h00, 1'b1);
        check("err_zero_flags", {29'd0, out_code, out_err, out_zero} >> 0, {27'd0, 3'd0, 1'b1, 1'b1});
        cycle("err_multi", 1'b1, 8'hA4, 1'b1);
        check("err_multi_flags", {27'd0, out_code, out_err, out_zero}, {27'd0, 3'd7, 1'b1, 1'b0});
        cycle("err_drain", 1'b0, 8'h00, 1'b1);
        check("err_count2", 32'(err_count), 32'd2);

        // Backpressure: fill, offer a third word, then release
        cycle("bp_push1", 1'b1, 8'h04, 1'b0);
        cycle("bp_push2", 1'b1, 8'h10, 1'b0);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        cycle("bp_hold1", 1'b1, 8'h40, 1'b0);
        cycle("bp_hold2", 1'b1, 8'h40, 1'b0);
        check("bp_stable_code", 32'(out_code), 32'd2);
        cycle("bp_pop1", 1'b1, 8'h40, 1'b1);
        check("bp_code4", 32'(out_code), 32'd4);
        cycle("bp_pop2", 1'b1, 8'h40, 1'b1);
        check("bp_code6", 32'(out_code), 32'd6);
        cycle("bp_drain", 1'b0, 8'h00, 1'b1);

        // Simultaneous push and pop while holding one entry
        cycle("sim_fill", 1'b1, 8'h01, 1'b0);
        cycle("sim_pushpop", 1'b1, 8'h08, 1'b1);
        check("sim_code3", 32'(out_code), 32'd3);
        check("sim_one_ready", 32'(in_ready), 32'd1);
        cycle("sim_drain", 1'b0, 8'h00, 1'b1);

        // Saturation on the 2-bit counter instance
        for (int k = 1; k <= 5; k++) begin
            in_valid2 = 1'b1;
            in_data2  = 8'h00;
            @(posedge clk);
            @(negedge clk);
            check("sat_count", 32'(err_count2), 32'((k < 3) ? k : 3));
        end
        in_valid2 = 1'b0;

        // Reset between edges with two results queued
        cycle("rst_fill1", 1'b1, 8'h02, 1'b0);
        cycle("rst_fill2", 1'b1, 8'h20, 1'b0);
        check("rst_full_code", 32'(out_code), 32'd1);
        #1;
        rst_n = 1'b0;
        q.delete();
        m_err = 0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_errcnt", 32'(err_count), 32'd0);
        check("rst_async_code", 32'(out_code), 32'd0);
        check("rst_async_sat", 32'(err_count2), 32'd0);
        #1;
        rst_n = 1'b1;
        cycle("rst_first_push", 1'b1, 8'h20, 1'b1);
        check("rst_code5", 32'(out_code), 32'd5);
        cycle("rst_drain", 1'b0, 8'h00, 1'b1);
        check("rst_no_stale", 32'(out_valid), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [7:0] d;
            int         sel;
            sel = $urandom_range(0, 3);
            if (sel == 0)      d = 8'h00;
            else if (sel == 1) d = 8'(1 << $urandom_range(0, 7));
            else               d = 8'($urandom);
            cycle("rand", ($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
